// File: rtl/laser_pkg.sv
// Shared types and constants for the laser echo emulator.
package laser_pkg;
  localparam int RANGE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    ECHO    = 2'd2,
    WAITLOW = 2'd3
  } state_e;
endpackage

// File: rtl/laser_echo_emulator_rise_detect.sv
// Rising-edge detector; previous sample resets high so a level held across reset is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
endmodule

// File: rtl/laser_echo_emulator.sv
// Emulates a target echo: on laser launch, returns a one-cycle sensor pulse after R cycles.
module laser_echo_emulator
  import laser_pkg::*;
#(
  parameter int W = RANGE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         L,
  input  logic [W-1:0] R,
  input  logic         E,
  output logic         S,
  output logic         BUSY,
  output logic [7:0]   ECHOES
);
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         s_q, s_d;
  logic         busy_q, busy_d;
  logic [7:0]   echoes_q, echoes_d;
  logic         launch;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (L),
    .rise  (launch)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = 1'b0;
    busy_d   = busy_q;
    echoes_d = echoes_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          if (E) begin
            // R=0 behaves as R=1 so the echo never coincides with the launch edge
            cnt_d   = (R == '0) ? W'(1) : R;
            busy_d  = 1'b1;
            state_d = DELAY;
          end else begin
            state_d = WAITLOW;
          end
        end
      end
      DELAY: begin
        if (cnt_q == W'(1)) begin
          state_d = ECHO;
          s_d     = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (echoes_q != 8'hFF) echoes_d = echoes_q + 8'd1;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      ECHO:    state_d = WAITLOW;
      WAITLOW: if (!L) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_q      <= 1'b0;
      busy_q   <= 1'b0;
      echoes_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      echoes_q <= echoes_d;
    end
  end

  assign S      = s_q;
  assign BUSY   = busy_q;
  assign ECHOES = echoes_q;
endmodule

// File: tb/tb_laser_echo_emulator.sv
// Scoreboard bench: expected echo cycle and count queued at launch, checked when S rises.
module tb_laser_echo_emulator;
  logic        clk = 1'b0;
  logic        reset;
  logic        L;
  logic [15:0] R;
  logic        E;
  logic        S;
  logic        BUSY;
  logic [7:0]  ECHOES;

  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned exp_echoes = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  laser_echo_emulator #(.W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .L      (L),
    .R      (R),
    .E      (E),
    .S      (S),
    .BUSY   (BUSY),
    .ECHOES (ECHOES)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (BUSY) busy_cnt++;
    if (S) begin
      if (q.size() == 0) chk("spurious_s", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("echo_cycle", cyc, e.cyc);
        chk("echo_count", ECHOES, e.cnt);
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic launch(input int unsigned r, input bit e, input bit toggle);
    exp_t x;
    @(negedge clk);
    L = 1'b1; R = 16'(r); E = e;
    if (e) begin
      if (exp_echoes < 255) exp_echoes++;
      x.cyc = cyc + 1 + ((r == 0) ? 1 : r);
      x.cnt = exp_echoes;
      q.push_back(x);
    end
    @(negedge clk);
    // R and E are only meaningful at the launch edge
    R = 16'($urandom_range(1, 4));
    E = 1'($urandom_range(0, 1));
    if (toggle) begin
      repeat (3) begin
        L = 1'b0; @(negedge clk);
        L = 1'b1; @(negedge clk);
      end
    end
    L = 1'b0;
    drain(70000);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned b0;
    reset = 1'b1; L = 1'b0; R = '0; E = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_s", S, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_echoes", ECHOES, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    b0 = busy_cnt;
    launch(10, 1'b1, 1'b0);
    chk("busy_len_r10", busy_cnt - b0, 10);
    chk("echoes_after_first", ECHOES, 1);

    launch(0, 1'b1, 1'b0);
    launch(1, 1'b1, 1'b0);

    b0 = busy_cnt;
    launch(7, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    chk("lost_echoes", ECHOES, exp_echoes);
    chk("lost_busy", busy_cnt - b0, 0);
    launch(5, 1'b1, 1'b0);

    launch(10, 1'b1, 1'b1);
    chk("toggle_echoes", ECHOES, exp_echoes);

    launch(65535, 1'b1, 1'b0);

    // Abort an in-flight pulse with reset, keep L high through release
    @(negedge clk);
    L = 1'b1; R = 16'd20; E = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_s", S, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_echoes", ECHOES, 0);
    reset = 1'b0;
    exp_echoes = 0;
    b0 = busy_cnt;
    repeat (30) @(negedge clk);
    chk("held_l_no_launch", busy_cnt - b0, 0);
    chk("held_l_echoes", ECHOES, 0);
    L = 1'b0;
    repeat (2) @(negedge clk);
    launch(5, 1'b1, 1'b0);
    chk("post_abort_echoes", ECHOES, 1);

    for (int i = 0; i < 260; i++) launch(2, 1'b1, 1'b0);
    chk("sat_echoes", ECHOES, 255);
    chk("final_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
